// File: rtl/pipe_skid_stage.sv
// Two-entry elastic pipeline stage with a main register and a skid register.
// The main register drives odat directly. The skid register catches the one
// word that arrives while the consumer stalls. iready, ovalid and occ are
// flops, so no input reaches any output combinationally.
module pipe_skid_stage #(
  parameter int unsigned      WIDTH       = 8,
  parameter logic [WIDTH-1:0] RESET_VALUE = {WIDTH{1'b0}}
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             ivalid,
  output logic             iready,
  input  logic [WIDTH-1:0] idat,
  output logic             ovalid,
  input  logic             oready,
  output logic [WIDTH-1:0] odat,
  output logic [1:0]       occ
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] main_q;
  logic [WIDTH-1:0] skid_q;
  logic             in_xfer;
  logic             out_xfer;
  logic             load_main;
  logic             load_skid;
  logic             main_from_skid;

  // The handshakes are built only from registered outputs and the partner's valid/ready.
  assign in_xfer  = ivalid & iready;
  assign out_xfer = ovalid & oready;
  assign odat     = main_q;

  // Next state and register load enables. Flush empties the stage and freezes the data.
  always_comb begin
    // NOTE: every signal gets a default first, so no path through the case leaves it unassigned (no latch).
    state_nxt      = state;
    load_main      = 1'b0;
    load_skid      = 1'b0;
    main_from_skid = 1'b0;
    unique case (state)
      EMPTY: begin
        if (in_xfer) begin
          load_main = 1'b1;
          state_nxt = ONE;
        end
      end
      ONE: begin
        if (in_xfer && out_xfer) begin
          load_main = 1'b1;
        end else if (in_xfer) begin
          load_skid = 1'b1;
          state_nxt = FULL;
        end else if (out_xfer) begin
          state_nxt = EMPTY;
        end
      end
      FULL: begin
        if (out_xfer) begin
          load_main      = 1'b1;
          main_from_skid = 1'b1;
          state_nxt      = ONE;
        end
      end
      default: state_nxt = EMPTY;
    endcase
    if (flush) begin
      state_nxt = EMPTY;
      load_main = 1'b0;
      load_skid = 1'b0;
    end
  end

  // State register. A reset clears it whatever the occupancy.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignment, so every flop samples the pre-edge values.
    if (rst) state <= EMPTY;
    else     state <= state_nxt;
  end

  // Handshake and occupancy flags, decoded from the next state so they are flop outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      ovalid <= 1'b0;
      iready <= 1'b1;
      occ    <= 2'd0;
    end else begin
      unique case (state_nxt)
        ONE: begin
          ovalid <= 1'b1;
          iready <= 1'b1;
          occ    <= 2'd1;
        end
        FULL: begin
          ovalid <= 1'b1;
          iready <= 1'b0;
          occ    <= 2'd2;
        end
        default: begin
          ovalid <= 1'b0;
          iready <= 1'b1;
          occ    <= 2'd0;
        end
      endcase
    end
  end

  // Data registers. They are plain enable flops, and the main register refills from skid when it drains.
  always_ff @(posedge clk) begin
    // NOTE: data registers are reset here because RESET_VALUE is visible on odat; normally data flops are left without a reset.
    if (rst) begin
      main_q <= RESET_VALUE;
      skid_q <= RESET_VALUE;
    end else begin
      if (load_main) main_q <= main_from_skid ? skid_q : idat;
      if (load_skid) skid_q <= idat;
    end
  end

endmodule

// File: tb/tb_pipe_skid_stage.sv
// Self-checking bench for pipe_skid_stage. The reference model is a FIFO queue
// of depth two plus a record of the last head word. Every cycle the DUT outputs
// are compared with the model. Directed scenarios also check fixed expected values.
module tb_pipe_skid_stage;

  localparam int unsigned W  = 8;
  localparam logic [W-1:0] RV = 8'hA5;

  logic         clk = 1'b0;
  logic         rst;
  logic         flush;
  logic         ivalid;
  logic         iready;
  logic [W-1:0] idat;
  logic         ovalid;
  logic         oready;
  logic [W-1:0] odat;
  logic [1:0]   occ;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: the queue of held words and the word the output register shows.
  logic [W-1:0] mq[$];
  logic [W-1:0] m_main;
  bit           m_live = 1'b0;

  always #5 clk = ~clk;

  pipe_skid_stage #(.WIDTH(W), .RESET_VALUE(RV)) dut (
    .clk    (clk),
    .rst    (rst),
    .flush  (flush),
    .ivalid (ivalid),
    .iready (iready),
    .idat   (idat),
    .ovalid (ovalid),
    .oready (oready),
    .odat   (odat),
    .occ    (occ)
  );

  // One clock: advance the model at the rising edge, then compare on the falling edge.
  task automatic cycle();
    logic         exp_ovalid;
    logic         exp_iready;
    logic [1:0]   exp_occ;
    @(posedge clk);
    if (rst) begin
      mq.delete();
      m_main = RV;
      m_live = 1'b1;
    end else if (m_live) begin
      bit acc;
      bit dep;
      acc = ivalid && (mq.size() < 2);
      dep = oready && (mq.size() > 0);
      if (flush) begin
        mq.delete();
      end else begin
        if (dep) void'(mq.pop_front());
        if (acc) mq.push_back(idat);
        if (mq.size() > 0) m_main = mq[0];
      end
    end
    @(negedge clk);
    if (m_live) begin
      exp_ovalid = (mq.size() != 0);
      exp_iready = (mq.size() < 2);
      exp_occ    = 2'(mq.size());
      n_checks++;
      if (ovalid !== exp_ovalid) begin
        n_fail++;
        $display("FAIL model_ovalid t=%0t: got %b expected %b", $time, ovalid, exp_ovalid);
      end
      n_checks++;
      if (iready !== exp_iready) begin
        n_fail++;
        $display("FAIL model_iready t=%0t: got %b expected %b", $time, iready, exp_iready);
      end
      n_checks++;
      if (occ !== exp_occ) begin
        n_fail++;
        $display("FAIL model_occ t=%0t: got %0d expected %0d", $time, occ, exp_occ);
      end
      n_checks++;
      if (odat !== m_main) begin
        n_fail++;
        $display("FAIL model_odat t=%0t: got %h expected %h", $time, odat, m_main);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; flush = 1'b1; ivalid = 1'b1; idat = 8'hFF; oready = 1'b1;
    cycle();
    cycle();
    rst = 1'b0; flush = 1'b0; ivalid = 1'b0; oready = 1'b0;
    n_checks++; if (odat !== RV)      begin n_fail++; $display("FAIL reset_odat: got %h expected %h", odat, RV); end
    n_checks++; if (ovalid !== 1'b0)  begin n_fail++; $display("FAIL reset_ovalid: got %b expected 0", ovalid); end
    n_checks++; if (iready !== 1'b1)  begin n_fail++; $display("FAIL reset_iready: got %b expected 1", iready); end
    n_checks++; if (occ !== 2'd0)     begin n_fail++; $display("FAIL reset_occ: got %0d expected 0", occ); end
    cycle();
    n_checks++; if (odat !== RV)      begin n_fail++; $display("FAIL reset_hold_odat: got %h expected %h", odat, RV); end
  endtask

  task automatic test_streaming();
    oready = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      ivalid = 1'b1;
      idat   = 8'(i);
      cycle();
      n_checks++; if (odat !== 8'(i))  begin n_fail++; $display("FAIL stream_odat[%0d]: got %h expected %h", i, odat, 8'(i)); end
      n_checks++; if (occ !== 2'd1)    begin n_fail++; $display("FAIL stream_occ[%0d]: got %0d expected 1", i, occ); end
      n_checks++; if (iready !== 1'b1) begin n_fail++; $display("FAIL stream_iready[%0d]: got %b expected 1", i, iready); end
    end
    ivalid = 1'b0;
    cycle();
    n_checks++; if (ovalid !== 1'b0) begin n_fail++; $display("FAIL stream_drain_ovalid: got %b expected 0", ovalid); end
    n_checks++; if (odat !== 8'h10)  begin n_fail++; $display("FAIL stream_drain_odat: got %h expected 10", odat); end
  endtask

  task automatic test_backpressure();
    oready = 1'b0; ivalid = 1'b1;
    idat = 8'h11; cycle();
    idat = 8'h22; cycle();
    n_checks++; if (occ !== 2'd2)    begin n_fail++; $display("FAIL bp_occ: got %0d expected 2", occ); end
    n_checks++; if (iready !== 1'b0) begin n_fail++; $display("FAIL bp_iready: got %b expected 0", iready); end
    n_checks++; if (odat !== 8'h11)  begin n_fail++; $display("FAIL bp_odat: got %h expected 11", odat); end
    idat = 8'h33;
    for (int i = 0; i < 3; i++) begin
      cycle();
      n_checks++; if (odat !== 8'h11) begin n_fail++; $display("FAIL bp_stable[%0d]: got %h expected 11", i, odat); end
      n_checks++; if (occ !== 2'd2)   begin n_fail++; $display("FAIL bp_no_accept[%0d]: got %0d expected 2", i, occ); end
    end
    ivalid = 1'b0; oready = 1'b1;
    cycle();
    n_checks++; if (odat !== 8'h22 || ovalid !== 1'b1) begin n_fail++; $display("FAIL bp_drain1: got %h/%b expected 22/1", odat, ovalid); end
    cycle();
    n_checks++; if (ovalid !== 1'b0) begin n_fail++; $display("FAIL bp_drain2: got %b expected 0", ovalid); end
    cycle();
    n_checks++; if (ovalid !== 1'b0) begin n_fail++; $display("FAIL bp_drain3: got %b expected 0", ovalid); end
    ivalid = 1'b1; idat = 8'h33; oready = 1'b0;
    cycle();
    n_checks++; if (odat !== 8'h33 || ovalid !== 1'b1) begin n_fail++; $display("FAIL bp_reoffer: got %h/%b expected 33/1", odat, ovalid); end
    ivalid = 1'b0; oready = 1'b1;
    cycle();
  endtask

  task automatic test_simultaneous();
    oready = 1'b0; ivalid = 1'b1; idat = 8'h40;
    cycle();
    idat = 8'h41; oready = 1'b1;
    cycle();
    n_checks++; if (odat !== 8'h41) begin n_fail++; $display("FAIL simul_odat: got %h expected 41", odat); end
    n_checks++; if (occ !== 2'd1)   begin n_fail++; $display("FAIL simul_occ: got %0d expected 1", occ); end
    idat = 8'h42; oready = 1'b0;
    cycle();
    n_checks++; if (occ !== 2'd2)   begin n_fail++; $display("FAIL simul_full: got %0d expected 2", occ); end
    ivalid = 1'b0; oready = 1'b1;
    cycle();
    n_checks++; if (odat !== 8'h42)  begin n_fail++; $display("FAIL simul_skid_odat: got %h expected 42", odat); end
    n_checks++; if (iready !== 1'b1) begin n_fail++; $display("FAIL simul_skid_iready: got %b expected 1", iready); end
    cycle();
  endtask

  task automatic test_flush();
    oready = 1'b0; ivalid = 1'b1;
    idat = 8'h55; cycle();
    idat = 8'h66; cycle();
    ivalid = 1'b0; flush = 1'b1;
    cycle();
    flush = 1'b0;
    n_checks++; if (ovalid !== 1'b0) begin n_fail++; $display("FAIL flush_ovalid: got %b expected 0", ovalid); end
    n_checks++; if (occ !== 2'd0)    begin n_fail++; $display("FAIL flush_occ: got %0d expected 0", occ); end
    n_checks++; if (iready !== 1'b1) begin n_fail++; $display("FAIL flush_iready: got %b expected 1", iready); end
    n_checks++; if (odat !== 8'h55)  begin n_fail++; $display("FAIL flush_data_held: got %h expected 55", odat); end
    ivalid = 1'b1; idat = 8'h77;
    cycle();
    n_checks++; if (odat !== 8'h77 || occ !== 2'd1) begin n_fail++; $display("FAIL flush_next: got %h/%0d expected 77/1", odat, occ); end
    ivalid = 1'b0; oready = 1'b1;
    cycle();
    n_checks++; if (ovalid !== 1'b0) begin n_fail++; $display("FAIL flush_no_ghost: got %b expected 0", ovalid); end
    // A word offered in the flush cycle is accepted and dropped.
    ivalid = 1'b1; idat = 8'h88; flush = 1'b1;
    cycle();
    flush = 1'b0; ivalid = 1'b0;
    n_checks++; if (ovalid !== 1'b0) begin n_fail++; $display("FAIL flush_discard: got %b expected 0", ovalid); end
    cycle();
  endtask

  task automatic test_mid_reset();
    oready = 1'b0; ivalid = 1'b1;
    idat = 8'h9A; cycle();
    idat = 8'h9B; cycle();
    ivalid = 1'b0; rst = 1'b1;
    cycle();
    rst = 1'b0;
    n_checks++; if (occ !== 2'd0 || ovalid !== 1'b0) begin n_fail++; $display("FAIL midrst_state: got %0d/%b expected 0/0", occ, ovalid); end
    n_checks++; if (odat !== RV) begin n_fail++; $display("FAIL midrst_odat: got %h expected %h", odat, RV); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 10000; i++) begin
      ivalid = 1'($urandom_range(0, 1));
      oready = 1'($urandom_range(0, 1));
      idat   = 8'($urandom);
      flush  = ($urandom_range(0, 99) == 0);
      rst    = ($urandom_range(0, 999) == 0);
      cycle();
    end
    rst = 1'b0; flush = 1'b0; ivalid = 1'b0; oready = 1'b0;
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; ivalid = 1'b0; oready = 1'b0; idat = '0;
    test_reset();
    test_streaming();
    test_backpressure();
    test_simultaneous();
    test_flush();
    test_mid_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
